alu_seq: RTL and testbench

Parametrised N-bit sequential ALU, successor to the single-cycle 32-bit ALU in the MIPS datapath. It keeps the full logical, shift and add/sub opcode set with a registered one-cycle result. It replaces the 16-bit multiply with an iterative full-width NxN unsigned multiply and adds an iterative unsigned divide, both returning HI/LO. The datapath controls it through a valid/ready handshake and stalls on IN_READY.

---
 rtl/global_pkg.sv | 27 ++
 rtl/alu_seq_iter_core.sv | 73 +++++++
 rtl/alu_seq.sv | 137 +++++++++++++
 tb/tb_alu_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/global_pkg.sv
// Shared widths, opcode and state encodings for the sequential ALU.
package global_pkg;

  localparam int N     = 32;
  localparam int M     = 5;
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0100,
    OP_SUB   = 4'b0101,
    OP_MULTU = 4'b0110,
    OP_DIVU  = 4'b0111,
    OP_OR    = 4'b1000,
    OP_AND   = 4'b1010,
    OP_XOR   = 4'b1011,
    OP_SLL   = 4'b1100,
    OP_SRL   = 4'b1101,
    OP_SRA   = 4'b1110
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_seq_iter_core.sv
// Shared iterative datapath: shift-add unsigned multiply and restoring divide
// over one 2N-bit accumulator, one step per clock while step is high.
module alu_iter_core
  import global_pkg::*;
#(
  parameter int N = global_pkg::N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic         step,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         last,
  output logic [N-1:0] res_hi,
  output logic [N-1:0] res_lo,
  output logic         b_zero
);

  localparam int CW = $clog2(N) + 1;

  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_nxt;
  logic [2*N-1:0] mul_nxt;
  logic [2*N-1:0] div_nxt;
  logic [N-1:0]   b_q;
  logic [CW-1:0]  cnt;
  logic           div_mode;
  logic [N:0]     mul_sum;
  logic [N:0]     rem_sh;
  logic [N:0]     rem_sub;

  // Multiply: acc = {partial product, remaining multiplier}, shifting right.
  // Divide:   acc = {remainder, remaining dividend / quotient}, shifting left.
  always_comb begin
    mul_sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, b_q} : '0);
    mul_nxt = {mul_sum, acc[N-1:1]};
    rem_sh  = acc[2*N-1:N-1];
    rem_sub = rem_sh - {1'b0, b_q};
    if (rem_sh >= {1'b0, b_q}) begin
      div_nxt = {rem_sub[N-1:0], acc[N-2:0], 1'b1};
    end else begin
      div_nxt = {rem_sh[N-1:0], acc[N-2:0], 1'b0};
    end
    acc_nxt = div_mode ? div_nxt : mul_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      div_mode <= 1'b0;
    end else if (start) begin
      acc      <= {{N{1'b0}}, a};
      b_q      <= b;
      cnt      <= '0;
      div_mode <= is_div;
    end else if (step) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
    end
  end

  // A zero divisor needs no special path: every step subtracts nothing,
  // giving an all-ones quotient and the dividend as remainder.
  assign last   = step && (cnt == CW'(N - 1));
  assign res_hi = acc_nxt[2*N-1:N];
  assign res_lo = acc_nxt[N-1:0];
  assign b_zero = (b_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Sequential N-bit ALU: registered single-cycle logic/shift/add ops plus
// iterative MULTU/DIVU behind a valid/ready request handshake.
module alu_seq
  import global_pkg::*;
#(
  parameter int N = global_pkg::N,
  parameter int M = global_pkg::M
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   OP,
  output logic         OUT_VALID,
  output logic [N-1:0] Y,
  output logic [N-1:0] HI,
  output logic         ZERO,
  output logic         OVF,
  output logic         DIV0,
  output alu_state_t   DBG_STATE
);

  // Handshake: a request transfers on a rising CLK edge with IN_VALID and
  // IN_READY both high; IN_VALID while IN_READY is low is simply not taken.
  alu_state_t   state;
  alu_state_t   state_nxt;
  logic         accept;
  logic         is_iter;
  logic         step;
  logic         last;
  logic         b_zero;
  logic [N-1:0] res_hi;
  logic [N-1:0] res_lo;
  logic [N-1:0] sc_y;
  logic         sc_ovf;
  logic [N-1:0] b_eff;
  logic [N-1:0] sum;
  logic [M-1:0] shamt;

  assign IN_READY  = (state == IDLE);
  assign accept    = IN_VALID && IN_READY;
  assign is_iter   = (OP == OP_MULTU) || (OP == OP_DIVU);
  assign step      = (state != IDLE);
  assign shamt     = B[M-1:0];
  assign ZERO      = (Y == '0);
  assign DBG_STATE = state;

  always_comb begin
    sc_y   = '0;
    sc_ovf = 1'b0;
    b_eff  = (OP == OP_SUB) ? (~B + 1'b1) : B;
    sum    = A + b_eff;
    case (OP)
      OP_OR:  sc_y = A | B;
      OP_AND: sc_y = A & B;
      OP_XOR: sc_y = A ^ B;
      OP_SLL: sc_y = A << shamt;
      OP_SRL: sc_y = A >> shamt;
      OP_SRA: sc_y = $signed(A) >>> shamt;
      OP_ADD, OP_SUB: begin
        sc_y   = sum;
        sc_ovf = (A[N-1] == b_eff[N-1]) && (sum[N-1] != A[N-1]);
      end
      default: sc_y = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && (OP == OP_MULTU)) begin
          state_nxt = MUL;
        end else if (accept && (OP == OP_DIVU)) begin
          state_nxt = DIV;
        end
      end
      MUL, DIV: begin
        if (last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  alu_iter_core #(.N(N)) u_core (
    .clk    (CLK),
    .rst    (RST),
    .start  (accept && is_iter),
    .is_div (OP == OP_DIVU),
    .step   (step),
    .a      (A),
    .b      (B),
    .last   (last),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .b_zero (b_zero)
  );

  // Result registers hold between results; OUT_VALID marks the update cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Y         <= '0;
      HI        <= '0;
      OVF       <= 1'b0;
      DIV0      <= 1'b0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      if (accept && !is_iter) begin
        Y         <= sc_y;
        HI        <= '0;
        OVF       <= sc_ovf;
        DIV0      <= 1'b0;
        OUT_VALID <= 1'b1;
      end else if (last) begin
        Y         <= res_lo;
        HI        <= res_hi;
        OVF       <= 1'b0;
        DIV0      <= (state == DIV) && b_zero;
        OUT_VALID <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus random ops, scored against
// an arithmetic reference model through an expected-result queue.
module tb_alu_seq;
  import global_pkg::*;

  localparam int W = 2*N + 2;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic [3:0]   OP = 4'b0000;
  logic         OUT_VALID;
  logic [N-1:0] Y;
  logic [N-1:0] HI;
  logic         ZERO;
  logic         OVF;
  logic         DIV0;
  alu_state_t   DBG_STATE;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  int           due_q[$];

  alu_seq dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .OP(OP), .OUT_VALID(OUT_VALID), .Y(Y), .HI(HI),
    .ZERO(ZERO), .OVF(OVF), .DIV0(DIV0), .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: {Y, HI, OVF, DIV0} from plain arithmetic.
  function automatic logic [W-1:0] model(input logic [N-1:0] a,
                                         input logic [N-1:0] b,
                                         input logic [3:0] op);
    logic [2*N-1:0] p;
    logic [N-1:0]   y, hi, bn, fill;
    logic           ovf, dz;
    int             s;
    y = '0; hi = '0; ovf = 1'b0; dz = 1'b0;
    s = int'(b[M-1:0]);
    case (op)
      4'b1000: y = a | b;
      4'b1010: y = a & b;
      4'b1011: y = a ^ b;
      4'b1100: y = a << s;
      4'b1101: y = a >> s;
      4'b1110: begin
        fill = '1;
        fill = ~(fill >> s);
        y = (a >> s) | (a[N-1] ? fill : '0);
      end
      4'b0100: begin
        y = a + b;
        ovf = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
      end
      4'b0101: begin
        bn = -b;
        y = a - b;
        ovf = (a[N-1] == bn[N-1]) && (y[N-1] != a[N-1]);
      end
      4'b0110: begin
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        y = p[N-1:0];
        hi = p[2*N-1:N];
      end
      4'b0111: begin
        if (b == '0) begin
          y = '1; hi = a; dz = 1'b1;
        end else begin
          y = a / b; hi = a % b;
        end
      end
      default: begin y = '0; hi = '0; end
    endcase
    return {y, hi, ovf, dz};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; holds the request until it is taken, returns at the
  // negedge after the accepting edge with IN_VALID dropped.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op);
    int waited = 0;
    IN_VALID = 1'b1; A = a; B = b; OP = op;
    while (!IN_READY && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    if (!IN_READY) begin
      chk("issue_timeout", 1'b0, 1'b1);
      IN_VALID = 1'b0;
    end else begin
      exp_q.push_back(model(a, b, op));
      due_q.push_back(cyc + 1 + (((op == 4'b0110) || (op == 4'b0111)) ? N : 0));
      @(posedge CLK);
      @(negedge CLK);
      IN_VALID = 1'b0;
    end
  endtask

  task automatic mon();
    logic [W-1:0] e;
    int d;
    if (!RST && OUT_VALID) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        chk("result", {Y, HI, OVF, DIV0}, e);
        chk("zero", ZERO, (e[W-1:N+2] == '0));
        chk("latency", cyc, d);
      end
    end
  endtask

  task automatic run();
    logic [3:0] op;
    logic [N-1:0] ra, rb;
    int waited;

    repeat (3) @(negedge CLK);
    chk("rst_ready", IN_READY, 1'b1);
    chk("rst_outs", {OUT_VALID, Y, HI, OVF, DIV0, ZERO}, {1'b0, {N{1'b0}}, {N{1'b0}}, 3'b001});
    chk("rst_state", DBG_STATE, IDLE);
    RST = 1'b0;
    @(negedge CLK);

    // Abort a multiply mid-iteration with an asynchronous reset.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0110);
    repeat (9) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("abort_ready", IN_READY, 1'b1);
    chk("abort_outs", {OUT_VALID, Y, HI, ZERO}, {1'b0, {N{1'b0}}, {N{1'b0}}, 1'b1});
    exp_q.delete();
    due_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(negedge CLK);

    issue(32'h7FFF_FFFF, 32'h0000_0001, 4'b0100);
    issue(32'h1234_5678, 32'h1234_5678, 4'b0101);
    issue(32'h8000_0000, 32'h0000_0004, 4'b1110);
    issue(32'h8000_0000, 32'h0000_0004, 4'b1101);
    issue(32'h0000_0001, 32'h0000_003F, 4'b1100);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0110);
    chk("busy_not_ready", IN_READY, 1'b0);
    issue(32'h0F0F_0000, 32'h0000_00F0, 4'b1000);
    issue(32'd100, 32'd7, 4'b0111);
    issue(32'h0000_ABCD, 32'h0000_0000, 4'b0111);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111);
    issue(32'h8000_0000, 32'h8000_0000, 4'b0100);
    issue(32'h0000_0000, 32'h8000_0000, 4'b0101);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 40)) : N'($urandom);
      issue(ra, rb, op);
      if ($urandom_range(0, 2) == 0) @(negedge CLK);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge CLK);
          mon();
        end
      end
      run();
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
